// File: rtl/ffl_pkg.sv
// Shared types and helpers for the flip-flop/latch library: FSM encoding and
// the round-robin winner search used by the shared-register arbiter.
package ffl_pkg;

    localparam int MAX_REQ   = 32;
    localparam int MAX_IDX_W = 5;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_GRANT = 1'b1;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } pick_t;

    // Scan n requesters starting just after 'last', wrapping, skipping masked bits.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input int unsigned        last,
                                      input logic [MAX_REQ-1:0] mask,
                                      input int unsigned        n);
        pick_t       r;
        int unsigned idx;
        r = '0;
        for (int unsigned i = 1; i <= MAX_REQ; i++) begin
            if (i <= n && !r.found) begin
                idx = last + i;
                if (idx >= n) idx = idx - n;
                if (req[idx[MAX_IDX_W-1:0]] && !mask[idx[MAX_IDX_W-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = idx[MAX_IDX_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dff_rr_arbiter_if.sv
// Requester-side bus of the shared-register arbiter: requests and data in,
// grant, register contents and status out.
interface dff_rr_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] data_in;
    logic [N_REQ-1:0]       gnt;
    logic [WIDTH-1:0]       q;
    logic                   q_valid;
    logic [IDX_W-1:0]       q_src;
    logic                   busy;

    modport master (
        output req, data_in,
        input  gnt, q, q_valid, q_src, busy
    );

    modport slave (
        input  req, data_in,
        output gnt, q, q_valid, q_src, busy
    );

endinterface

// File: rtl/dff_reg_en.sv
// WIDTH-bit D register with synchronous active-high reset and load enable.
module dff_reg_en #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/dff_rr_arbiter.sv
// Round-robin arbiter sharing one D register between N_REQ requesters; one
// grant per cycle, the granted word is loaded at the edge closing the grant.
module dff_rr_arbiter
    import ffl_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic            clk,
    input  logic            rst,
    dff_rr_arbiter_if.slave bus
);

    state_t             state;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   q_src_r;
    logic [N_REQ-1:0]   gnt_r;
    logic               q_valid_r;
    logic [MAX_REQ-1:0] mask;
    logic [IDX_W-1:0]   base;
    pick_t              pick;
    logic [IDX_W-1:0]   next_sel;
    logic [WIDTH-1:0]   sel_data;
    logic               load;

    // In GRANT the pointer is about to become sel, so the scan starts there
    // and the current holder is excluded for this one edge only.
    always_comb begin
        mask = '0;
        base = last;
        if (state == ST_GRANT) begin
            mask[sel] = 1'b1;
            base      = sel;
        end
        pick     = rr_pick(MAX_REQ'(bus.req), 32'(base), mask, N_REQ);
        next_sel = IDX_W'(pick.idx);
    end

    assign load     = (state == ST_GRANT);
    assign sel_data = bus.data_in[sel*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sel       <= '0;
            last      <= IDX_W'(N_REQ - 1);
            gnt_r     <= '0;
            q_valid_r <= 1'b0;
            q_src_r   <= '0;
        end else begin
            q_valid_r <= 1'b0;
            if (state == ST_GRANT) begin
                q_src_r   <= sel;
                q_valid_r <= 1'b1;
                last      <= sel;
            end
            if (pick.found) begin
                state <= ST_GRANT;
                sel   <= next_sel;
                gnt_r <= N_REQ'(1) << next_sel;
            end else begin
                state <= ST_IDLE;
                gnt_r <= '0;
            end
        end
    end

    dff_reg_en #(.WIDTH(WIDTH)) u_q_reg (
        .clk (clk),
        .rst (rst),
        .en  (load),
        .d   (sel_data),
        .q   (bus.q)
    );

    assign bus.gnt     = gnt_r;
    assign bus.q_valid = q_valid_r;
    assign bus.q_src   = q_src_r;
    assign bus.busy    = (state == ST_GRANT);

endmodule

// File: doc/dff_rr_arbiter.md
# dff_rr_arbiter

Round-robin arbiter that shares one WIDTH-bit D-flip-flop storage register between N_REQ requesters. Each requester raises a level request with its data. The arbiter grants exactly one requester per grant cycle and loads that requester's data into the shared register. The register output, a valid pulse and the source index feed downstream logic. It sits between independent producers and the single shared register in the flip-flop/latch library.

## Interface
- `N_REQ`, default 4: number of requesters; must be ≥ 2.
- `WIDTH`, default 8: width of each data word and of the shared register.
- `IDX_W`, default `$clog2(N_REQ)`: width of the source index. Derived; do not override.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `req`  in  N_REQ: level request; bit i belongs to requester i.
- `data_in`  in  N_REQ*WIDTH: flat data bus; requester i owns bits [i*WIDTH +: WIDTH].
- `gnt`  out  N_REQ: registered one-hot grant; all zeros when idle.
- `q`  out  WIDTH: shared register contents.
- `q_valid`  out  1: one-cycle pulse when `q` has just been loaded.
- `q_src`  out  IDX_W: index of the requester whose data is in `q`.
- `busy`  out  1: high while the FSM is in GRANT.

## Operation
- The FSM has two states:
  - IDLE: `gnt` is 0. At a rising edge with any `req` bit set, latch the winner index into `sel`, set `gnt[sel]`, and go to GRANT.
  - GRANT: `gnt[sel]` is high for this cycle. At the closing edge:
    - `q` ← `data_in[sel]`, `q_src` ← `sel`, `q_valid` ← 1, pointer `last` ← `sel`.
    - Then pick the next winner from `req` with bit `sel` masked. If one exists, stay in GRANT with the new `sel` (back-to-back, no gap). Otherwise go to IDLE.
- Winner selection: scan from `last+1` upward and wrap modulo N_REQ. The first set bit wins, so the most recently served requester has lowest priority.
- Mask rule: the holder's `req` is ignored only at the edge that closes its own grant cycle. A holder that keeps `req` high is eligible again at the next edge.
- Requester contract: hold `data_in` stable while `req` is high, up to and including the `gnt` cycle. Drop `req` after seeing `gnt` to avoid a repeat grant.
- `q` and `q_src` hold their value until the next load.
- `q_valid` is 0 in every cycle that does not immediately follow a load.

## Timing
- Reset values: FSM = IDLE, `gnt` = 0, `q` = 0, `q_valid` = 0, `q_src` = 0, `busy` = 0, `last` = N_REQ-1. With these values, requester 0 has top priority after reset.
- Latency:
  - `req` sampled high at edge k (FSM in IDLE) gives `gnt` high during cycle k→k+1.
  - `q`, `q_valid` and `q_src` update at edge k+1.
  - Request to data: 2 edges.
- Throughput: with continuous contention, one grant and one load per cycle.
- `rst` high at any edge overrides everything:
  - A grant in flight is dropped, `q` is not loaded and returns to 0.
  - `q_valid` is 0 in the following cycle.
- A `req` bit that drops during its own `gnt` cycle is still served; the capture is unconditional.
- A `req` bit that rises and falls between edges is never seen.

## Structure
- Shared package `ffl_pkg`:
  - state encoding typedef: `ST_IDLE`, `ST_GRANT`
  - `function automatic rr_pick(req, last, mask)` returning index plus found flag
- Sub-module `dff_reg_en`: WIDTH-bit D register with synchronous active-high reset and load enable. One instance for `q`, built in the same style as the library's `d_ff`.
- FSM, pointer, `gnt`, `q_valid` and `q_src` live in the top.

## Test plan
- Reset: hold `rst` for 2 edges with arbitrary `req` → `gnt` = 0, `q` = 0, `q_valid` = 0, `busy` = 0 throughout, and one cycle after release.
- Single request: `req` = 4'b0100, `data_in[2]` = 8'hA5 at edge k → `gnt` = 4'b0100 in cycle k+1. After edge k+1: `q` = 8'hA5, `q_src` = 2, one-cycle `q_valid` pulse, FSM back in IDLE.
- Full contention: `req` = 4'b1111 held, data i = 8'h10+i → grants 0,1,2,3,0 on consecutive cycles, `q` = 10,11,12,13,10, `q_valid` high every cycle.
- Fairness ordering: `last` = 1, then `req` = 4'b1010 → requester 3 granted first, then requester 1 in the next cycle.
- Sticky holder: `req` = 4'b0001 held forever → grants at cycles k+1, k+3, k+5, with one IDLE cycle between due to the mask.
- Mid-grant reset: `rst` asserted at the edge closing a GRANT cycle with `data_in` = 8'h3C → `q` = 0 (not 3C), `q_valid` = 0, `gnt` = 0. The next request after release is served with requester-0-first priority.
